// File: rtl/scan_sequencer.sv
// Channel scanner driving a downstream 3-to-8 one-hot decoder: steps through enabled
// channels with a programmable dwell, blanking gaps between slots, continuous or single pass.
module scan_sequencer #(
  parameter int TICK_DIV = 1000,
  parameter int BLANK    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       stop,
  input  logic       mode,
  input  logic [7:0] mask,
  output logic [2:0] sel,
  output logic       sel_en,
  output logic       busy,
  output logic       done,
  output logic       wrap
);
  localparam int MAXC = (TICK_DIV > BLANK) ? TICK_DIV : BLANK;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] TD_LAST = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0] BL_LAST = CW'(BLANK - 1);

  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_BLANK} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    sel_q;
  logic          sel_en_q, busy_q, done_q, wrap_q, mode_q;

  logic [2:0]    first_sel_d, nxt_sel_d;
  logic          nxt_wrap_d, found_d, adv_d;

  // Lowest enabled channel for start, and circular next-above search for advance.
  always_comb begin
    first_sel_d = 3'd0;
    for (int i = 7; i >= 0; i--)
      if (mask[i]) first_sel_d = 3'(i);
    nxt_sel_d  = sel_q;
    nxt_wrap_d = 1'b0;
    found_d    = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      if (!found_d && mask[sel_q + 3'(k)]) begin
        found_d    = 1'b1;
        nxt_sel_d  = sel_q + 3'(k);
        nxt_wrap_d = ((sel_q + 3'(k)) <= sel_q);
      end
    end
  end

  assign adv_d = ((state_q == S_DWELL) && (cnt_q == TD_LAST) && (BLANK == 0)) ||
                 ((state_q == S_BLANK) && (cnt_q == BL_LAST));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= 3'd0;
      sel_en_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      wrap_q   <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      wrap_q <= 1'b0;
      if (stop) begin
        state_q  <= S_IDLE;
        cnt_q    <= '0;
        sel_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (adv_d) begin
        cnt_q <= '0;
        if (mask == 8'd0) begin
          state_q  <= S_IDLE;
          sel_en_q <= 1'b0;
          busy_q   <= 1'b0;
        end else if (nxt_wrap_d && mode_q) begin
          state_q  <= S_IDLE;
          sel_en_q <= 1'b0;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          wrap_q   <= 1'b1;
        end else begin
          state_q  <= S_DWELL;
          sel_q    <= nxt_sel_d;
          sel_en_q <= 1'b1;
          wrap_q   <= nxt_wrap_d;
        end
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start && (mask != 8'd0)) begin
              state_q  <= S_DWELL;
              cnt_q    <= '0;
              sel_q    <= first_sel_d;
              sel_en_q <= 1'b1;
              busy_q   <= 1'b1;
              mode_q   <= mode;
            end
          end
          S_DWELL: begin
            if (cnt_q == TD_LAST) begin
              state_q  <= S_BLANK;
              cnt_q    <= '0;
              sel_en_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          S_BLANK: cnt_q <= cnt_q + 1'b1;
          default: begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign sel    = sel_q;
  assign sel_en = sel_en_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign wrap   = wrap_q;
endmodule

// File: tb/tb_scan_sequencer.sv
// Directed bench for scan_sequencer with TICK_DIV = 4, BLANK = 1 (5-cycle slots).
module tb_scan_sequencer;
  logic       clk, rst_n, start, stop, mode;
  logic [7:0] mask;
  logic [2:0] sel;
  logic       sel_en, busy, done, wrap;
  int         checks, errors;
  logic [2:0] seq3 [3];

  scan_sequencer #(.TICK_DIV(4), .BLANK(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .mode(mode), .mask(mask),
    .sel(sel), .sel_en(sel_en), .busy(busy), .done(done), .wrap(wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0; errors = 0;
    seq3[0] = 3'd2; seq3[1] = 3'd5; seq3[2] = 3'd7;
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; mode = 1'b0; mask = 8'hFF;

    // 1: reset held with start asserted
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_sel", 8'(sel), 8'd0);
      chk("rst_sel_en", 8'(sel_en), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_wrap", 8'(wrap), 8'd0);
    end
    start = 1'b0; rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("post_rst_busy", 8'(busy), 8'd0);
      chk("post_rst_sel_en", 8'(sel_en), 8'd0);
    end

    // 2: continuous, full mask
    mask = 8'hFF; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 40; t++) begin
      chk("cont_sel", 8'(sel), 8'((t / 5) % 8));
      chk("cont_sel_en", 8'(sel_en), 8'((t % 5) < 4));
      chk("cont_wrap", 8'(wrap), 8'(t == 40));
      chk("cont_busy", 8'(busy), 8'd1);
      chk("cont_done", 8'(done), 8'd0);
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("cont_stop_busy", 8'(busy), 8'd0);

    // 3: single pass over channels 2,5,7
    mask = 8'b1010_0100; mode = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 15; t++) begin
      chk("sp_sel", 8'(sel), 8'(seq3[t / 5]));
      chk("sp_sel_en", 8'(sel_en), 8'((t % 5) < 4));
      chk("sp_busy", 8'(busy), 8'd1);
      chk("sp_done", 8'(done), 8'd0);
      chk("sp_wrap", 8'(wrap), 8'd0);
      tick();
    end
    chk("sp_end_done", 8'(done), 8'd1);
    chk("sp_end_wrap", 8'(wrap), 8'd1);
    chk("sp_end_busy", 8'(busy), 8'd0);
    chk("sp_end_sel", 8'(sel), 8'd7);
    chk("sp_end_sel_en", 8'(sel_en), 8'd0);
    tick();
    chk("sp_after_done", 8'(done), 8'd0);
    chk("sp_after_wrap", 8'(wrap), 8'd0);

    // 4: empty mask start is ignored
    mask = 8'h00; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("empty_busy", 8'(busy), 8'd0);
      chk("empty_sel_en", 8'(sel_en), 8'd0);
      chk("empty_done", 8'(done), 8'd0);
      chk("empty_wrap", 8'(wrap), 8'd0);
      chk("empty_sel", 8'(sel), 8'd7);
      tick();
    end

    // 5: abort during 2nd dwell cycle of sel=3, then start+stop together
    mask = 8'hFF; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t < 16; t++) tick();
    chk("abort_pre_sel", 8'(sel), 8'd3);
    chk("abort_pre_sel_en", 8'(sel_en), 8'd1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("abort_sel_en", 8'(sel_en), 8'd0);
    chk("abort_busy", 8'(busy), 8'd0);
    chk("abort_sel", 8'(sel), 8'd3);
    chk("abort_done", 8'(done), 8'd0);
    chk("abort_wrap", 8'(wrap), 8'd0);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("startstop_busy", 8'(busy), 8'd0);
    chk("startstop_sel_en", 8'(sel_en), 8'd0);
    tick();
    chk("startstop_busy2", 8'(busy), 8'd0);

    // 6: single channel 4, then mask moves to channel 0 mid-dwell
    mask = 8'h10; mode = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    for (int t = 0; t <= 25; t++) begin
      chk("single_sel", 8'(sel), (t < 20) ? 8'd4 : 8'd0);
      chk("single_sel_en", 8'(sel_en), 8'((t % 5) < 4));
      chk("single_wrap", 8'(wrap), 8'((t > 0) && ((t % 5) == 0)));
      chk("single_busy", 8'(busy), 8'd1);
      if (t == 16) mask = 8'h01;
      tick();
    end
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk("final_busy", 8'(busy), 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/scan_sequencer.md
Name: scan_sequencer

Overview:
Sequential channel scanner that produces the 3-bit select code and enable for the team's 3-to-8 one-hot decoder, which sits directly downstream. It steps through eight channel indices under a programmable dwell time, skips masked channels, and inserts blanking gaps between slots so decoder outputs never overlap. It supports continuous scanning (display/LED multiplexing) and single-pass operation with a completion handshake.

Parameters:
TICK_DIV, 1000, clock cycles sel_en is held high per slot; legal range >= 1.
BLANK, 2, clock cycles sel_en is held low between slots; legal range >= 0, where 0 means no gap.

Ports:
clk    input   1  system clock; all logic updates on the rising edge.
rst_n  input   1  synchronous reset, active-low.
start  input   1  begin scan; sampled only in IDLE.
stop   input   1  synchronous abort; takes effect from any state.
mode   input   1  0 = continuous, 1 = single pass; sampled when start is accepted.
mask   input   8  bit i = 1 enables channel index i.
sel    output  3  channel index; drives the decoder's select input.
sel_en output  1  drives the decoder's enable input.
busy   output  1  high while not in IDLE.
done   output  1  one-cycle pulse at the end of a single pass.
wrap   output  1  one-cycle pulse each time a pass completes.

Behaviour:
- All outputs are registered.
- Reset (rst_n = 0 at a clock edge):
  - state goes to IDLE; sel, sel_en, busy, done, wrap are all 0; internal counters are 0.
  - Reset mid-scan aborts immediately, with no done or wrap pulse.
- States: IDLE, DWELL, BLANK.
- IDLE:
  - Start is accepted when start = 1, stop = 0 and mask != 0.
  - On acceptance, the next cycle enters DWELL with sel = lowest set mask bit, sel_en = 1, busy = 1; mode is latched.
  - start with mask == 0 is ignored: no output change.
- DWELL:
  - sel_en = 1 for exactly TICK_DIV cycles.
  - Then enter BLANK (sel_en = 0), or advance directly if BLANK = 0.
- BLANK: sel_en = 0 for exactly BLANK cycles; sel holds its value.
- Advance (at the end of BLANK, or at the end of DWELL if BLANK = 0):
  - mask is re-sampled at this point.
  - Next index = next set mask bit strictly above the current sel, searching circularly 7 -> 0.
  - If the search passes index 7 (next <= current, including a single enabled channel), the pass is complete and wrap pulses in the first cycle of the new slot, or in the IDLE-return cycle.
  - Pass complete with latched mode = 1: return to IDLE; done = 1 and wrap = 1 for one cycle; busy = 0 in that same cycle; sel holds its last value.
  - Pass complete with latched mode = 0: continue in DWELL at the next index.
  - mask == 0 at advance: return to IDLE, busy = 0, no done, no wrap.
- stop:
  - Has priority over all other inputs, including start in the same cycle.
  - The next cycle is IDLE, with sel_en = 0, busy = 0, sel held, and no done or wrap.
- start while busy is ignored.
- mask changes during a slot have no effect until the next advance.
- Slot period = TICK_DIV + BLANK cycles. sel changes only while sel_en = 0, or in the same cycle sel_en rises from IDLE/BLANK; it never changes while sel_en stays high, except when BLANK = 0.
- Counter width is $clog2(max(TICK_DIV, BLANK) + 1).

Test Plan:
All scenarios use TICK_DIV = 4, BLANK = 1.
1. Reset: hold rst_n = 0 for 3 cycles with start = 1, mask = FF -> sel = 0, sel_en = 0, busy = 0, done = 0, wrap = 0 throughout; no scan after rst_n rises until a new start.
2. Continuous, full mask: mask = FF, mode = 0, pulse start -> sel steps 0, 1, ..., 7, each with sel_en high for 4 cycles then low for 1; wrap pulses exactly 40 cycles after the first sel_en, coincident with sel = 0 and sel_en = 1; busy stays 1.
3. Single pass: mask = 8'b1010_0100, mode = 1 -> sel sequence 2, 5, 7; done = wrap = 1 for one cycle, 15 cycles after the first sel_en; busy = 0 in that cycle; sel holds 7.
4. Empty mask: mask = 00, pulse start -> busy, sel_en, done, wrap all remain 0.
5. Abort: stop during the 2nd dwell cycle of sel = 3 -> next cycle sel_en = 0, busy = 0, sel = 3, no done. Separately, start and stop in the same IDLE cycle -> remains IDLE.
6. Single channel and mask change: mask = 8'h10, mode = 0 -> sel = 4 constantly, wrap every 5 cycles. Change mask to 8'h01 mid-dwell -> current slot completes at sel = 4, then sel = 0 from the next advance, with wrap asserted.
